regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Register file plus busy scoreboard, directly downstream of the register-field decoder.
- Two read ports consume the decoder's extended addresses (Rd-class port A, Rp-class port B, 4-bit each).
- Returns operand data one cycle later. Tracks registers with an in-flight producer and stalls reads of them until write-back.
- Register 0 is hardwired zero.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width; register count NREGS = 2**ADDR_W = 16

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- rd_en  input  1  read request for both ports this cycle
- rd_addr_a  input  ADDR_W  port A address (extended Rd, 12..15 in normal use)
- rd_addr_b  input  ADDR_W  port B address (extended Rp, 8..11 in normal use)
- rd_data_a  output  DATA_W  registered port A operand
- rd_data_b  output  DATA_W  registered port B operand
- rd_valid  output  1  rd_data_a/b hold a completed read (one cycle after accepted request)
- busy_a  output  1  combinational: port A address has pending producer not resolved this cycle
- busy_b  output  1  same for port B
- stall  output  1  combinational: rd_en && (busy_a || busy_b); request not accepted
- iss_en  input  1  instruction issued that will write iss_addr
- iss_addr  input  ADDR_W  destination being reserved
- wr_en  input  1  write-back strobe
- wr_addr  input  ADDR_W  write-back destination
- wr_data  input  DATA_W  write-back value

Behaviour:
- Reset (rst high at edge, overrides all other inputs):
  - all 16 registers := 0
  - busy vector := 0
  - rd_data_a/b := 0
  - rd_valid := 0
- Register 0:
  - reads always return 0
  - writes ignored
  - iss_en to address 0 never sets busy[0]
- Write-back: at edge with wr_en=1 and wr_addr!=0:
  - reg[wr_addr] := wr_data
  - busy[wr_addr] := 0
- Issue: at edge with iss_en=1 and iss_addr!=0, busy[iss_addr] := 1.
- Same edge, iss_en and wr_en to the same nonzero address:
  - register takes wr_data
  - busy ends 1 (new producer wins)
- Effective busy (combinational):
  - busy_x = busy[rd_addr_x] && !(wr_en && wr_addr==rd_addr_x && wr_addr!=0)
  - a same-cycle write-back resolves the hazard
  - issue in the same cycle does NOT affect busy_x (takes effect next cycle)
- stall = rd_en && (busy_a || busy_b). Combinational, no registered delay.
- Accepted read (rd_en=1, stall=0), at edge:
  - rd_data_x := 0 if rd_addr_x==0
  - else wr_data if wr_en && wr_addr==rd_addr_x (write-first bypass)
  - else reg[rd_addr_x]
  - rd_valid := 1
  - Latency exactly 1 cycle.
- Stalled read (rd_en=1, stall=1):
  - rd_valid := 0
  - rd_data_a/b hold previous values
  - requester must hold rd_en and addresses until stall drops
- No request (rd_en=0): rd_valid := 0; rd_data held.
- Both ports may address the same register; both receive the same value.
- Back-to-back accepted reads give rd_valid high continuously; one result per cycle.
- Reset asserted mid-stall:
  - busy cleared, so the next cycle with rd_en is accepted with data 0
  - rd_valid stays 0 during the reset cycle
- Multiple reservations of one register before write-back:
  - single busy bit; first write-back clears it
  - no counting; issue logic must not double-reserve

Test Plan:
- Reset, then rd_en with addr_a=12, addr_b=8 -> next cycle rd_valid=1, rd_data_a=0, rd_data_b=0, stall=0 throughout.
- Write 0x1234 to 13 and 0xBEEF to 9 on consecutive cycles, then read a=13, b=9 -> rd_data_a=0x1234, rd_data_b=0xBEEF one cycle after request.
- Same-cycle bypass: wr_en to 14 with 0x00A5 while rd_en a=14 -> rd_data_a=0x00A5 next cycle (not the old value).
- Hazard: iss_en to 10; next cycle rd_en b=10 -> stall=1, busy_b=1, rd_valid=0 next cycle. Write-back 0x7777 to 10 three cycles later with rd_en held -> stall=0 that cycle, rd_data_b=0x7777 and rd_valid=1 next cycle.
- Register 0: wr_en addr 0 data 0xFFFF plus iss_en addr 0, then read a=0 -> stall=0, rd_data_a=0.
- Simultaneous iss_en and wr_en to 11 with 0x0042 -> reg[11]=0x0042, busy[11]=1. Following read of 11 stalls until a later write-back.
- rst asserted while a read of busy register 15 is stalled -> rd_valid=0, busy cleared. Next rd_en of 15 accepted, data 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a one-bit-per-register busy scoreboard and two registered read ports.
// Reads of a register with an unresolved producer stall until its write-back arrives.
module regfile_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_q, rd_valid_d;

  logic wr_ok_s;
  logic iss_ok_s;
  logic wr_hit_a_s;
  logic wr_hit_b_s;
  logic accept_s;

  // Hazard detection; a write-back in the same cycle resolves the hazard.
  always_comb begin
    wr_ok_s    = wr_en && (wr_addr != {ADDR_W{1'b0}});
    iss_ok_s   = iss_en && (iss_addr != {ADDR_W{1'b0}});
    wr_hit_a_s = wr_ok_s && (wr_addr == rd_addr_a);
    wr_hit_b_s = wr_ok_s && (wr_addr == rd_addr_b);
    busy_a     = busy_q[rd_addr_a] && !wr_hit_a_s;
    busy_b     = busy_q[rd_addr_b] && !wr_hit_b_s;
    stall      = rd_en && (busy_a || busy_b);
    accept_s   = rd_en && !stall;
  end

  // Scoreboard next state: write-back clears first so a same-edge issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok_s) begin
      busy_d[wr_addr] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_ok_s) begin
      busy_d[iss_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Read port next state with write-first bypass; outputs hold when not accepted.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_valid_d  = 1'b0;
    if (accept_s) begin
      rd_valid_d = 1'b1;
      if (rd_addr_a == {ADDR_W{1'b0}}) begin
        rd_data_a_d = {DATA_W{1'b0}};
      end else if (wr_hit_a_s) begin
        rd_data_a_d = wr_data;
      end else begin
        rd_data_a_d = regs_q[rd_addr_a];
      end
      if (rd_addr_b == {ADDR_W{1'b0}}) begin
        rd_data_b_d = {DATA_W{1'b0}};
      end else if (wr_hit_b_s) begin
        rd_data_b_d = wr_data;
      end else begin
        rd_data_b_d = regs_q[rd_addr_b];
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Register storage; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Scoreboard and read-port state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= {NREGS{1'b0}};
      rd_data_a_q <= {DATA_W{1'b0}};
      rd_data_b_q <= {DATA_W{1'b0}};
      rd_valid_q  <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against a behavioural
// model of register contents and pending producers.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid, busy_a, busy_b, stall;
  logic        iss_en;
  logic [3:0]  iss_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  int errors = 0;
  int checks = 0;

  // model state
  logic [15:0] m_regs [16];
  bit          m_pending [16];
  logic [15:0] exp_a, exp_b;
  logic        exp_valid;
  logic        obs_stall;

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
    .busy_a(busy_a), .busy_b(busy_b), .stall(stall),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic re, input logic [3:0] a, input logic [3:0] b,
                       input logic ie, input logic [3:0] ia,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd);
    rst = r; rd_en = re; rd_addr_a = a; rd_addr_b = b;
    iss_en = ie; iss_addr = ia; wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] ad);
    if (ad == 4'd0) return 16'h0000;
    if (wr_en && wr_addr == ad) return wr_data;
    return m_regs[ad];
  endfunction

  function automatic logic pending_now(input logic [3:0] ad);
    // a write-back arriving this cycle retires the producer
    if (ad == 4'd0) return 1'b0;
    if (wr_en && wr_addr == ad) return 1'b0;
    return m_pending[ad];
  endfunction

  // One clock: check combinational outputs before the edge, advance the model, check after.
  task automatic cycle();
    logic eba, ebb, est;
    #1;
    eba = pending_now(rd_addr_a);
    ebb = pending_now(rd_addr_b);
    est = rd_en && (eba || ebb);
    obs_stall = stall;
    chk("busy_a", {31'd0, busy_a}, {31'd0, eba});
    chk("busy_b", {31'd0, busy_b}, {31'd0, ebb});
    chk("stall", {31'd0, stall}, {31'd0, est});
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = 16'h0000;
        m_pending[i] = 1'b0;
      end
      exp_a = 16'h0000; exp_b = 16'h0000; exp_valid = 1'b0;
    end else begin
      exp_valid = rd_en && !est;
      if (exp_valid) begin
        exp_a = model_read(rd_addr_a);
        exp_b = model_read(rd_addr_b);
      end
      if (wr_en && wr_addr != 4'd0) begin
        m_regs[wr_addr] = wr_data;
        m_pending[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 4'd0) m_pending[iss_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
    chk("rd_data_a", {16'd0, rd_data_a}, {16'd0, exp_a});
    chk("rd_data_b", {16'd0, rd_data_b}, {16'd0, exp_b});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0000;
      m_pending[i] = 1'b0;
    end
    exp_a = 16'h0000; exp_b = 16'h0000; exp_valid = 1'b0;

    // reset
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
    cycle(); cycle();
    chk("reset_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_data_a", {16'd0, rd_data_a}, 32'd0);

    // first read after reset
    drive(1'b0, 1'b1, 4'd12, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
    cycle();
    chk("first_stall", {31'd0, obs_stall}, 32'd0);
    chk("first_valid", {31'd0, rd_valid}, 32'd1);
    chk("first_data_b", {16'd0, rd_data_b}, 32'd0);

    // writes then read back
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd13, 16'h1234); cycle();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd9, 16'hBEEF);  cycle();
    chk("idle_valid", {31'd0, rd_valid}, 32'd0);
    drive(1'b0, 1'b1, 4'd13, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); cycle();
    chk("rd13", {16'd0, rd_data_a}, 32'h1234);
    chk("rd9", {16'd0, rd_data_b}, 32'hBEEF);

    // same-cycle bypass
    drive(1'b0, 1'b1, 4'd14, 4'd8, 1'b0, 4'd0, 1'b1, 4'd14, 16'h00A5); cycle();
    chk("bypass", {16'd0, rd_data_a}, 32'h00A5);

    // hazard on register 10
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd10, 1'b0, 4'd0, 16'h0000); cycle();
    drive(1'b0, 1'b1, 4'd12, 4'd10, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); cycle();
    chk("hz_stall", {31'd0, obs_stall}, 32'd1);
    chk("hz_busy_b", {31'd0, busy_b}, 32'd1);
    chk("hz_valid", {31'd0, rd_valid}, 32'd0);
    cycle(); cycle();
    drive(1'b0, 1'b1, 4'd12, 4'd10, 1'b0, 4'd0, 1'b1, 4'd10, 16'h7777); cycle();
    chk("hz_wb_stall", {31'd0, obs_stall}, 32'd0);
    chk("hz_wb_valid", {31'd0, rd_valid}, 32'd1);
    chk("hz_wb_data", {16'd0, rd_data_b}, 32'h7777);

    // register 0
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 16'hFFFF); cycle();
    drive(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); cycle();
    chk("r0_stall", {31'd0, obs_stall}, 32'd0);
    chk("r0_data", {16'd0, rd_data_a}, 32'd0);

    // simultaneous issue and write-back to 11
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd11, 1'b1, 4'd11, 16'h0042); cycle();
    drive(1'b0, 1'b1, 4'd11, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); cycle();
    chk("r11_stall", {31'd0, obs_stall}, 32'd1);
    cycle();
    drive(1'b0, 1'b1, 4'd11, 4'd8, 1'b0, 4'd0, 1'b1, 4'd11, 16'h0055); cycle();
    chk("r11_wb", {16'd0, rd_data_a}, 32'h0055);

    // reset during a stalled read of 15
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 1'b0, 4'd0, 16'h0000); cycle();
    drive(1'b0, 1'b1, 4'd15, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); cycle();
    chk("r15_stall", {31'd0, obs_stall}, 32'd1);
    drive(1'b1, 1'b1, 4'd15, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); cycle();
    chk("r15_rst_valid", {31'd0, rd_valid}, 32'd0);
    drive(1'b0, 1'b1, 4'd15, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); cycle();
    chk("r15_after_stall", {31'd0, obs_stall}, 32'd0);
    chk("r15_after_valid", {31'd0, rd_valid}, 32'd1);
    chk("r15_after_data", {16'd0, rd_data_a}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            16'($urandom));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
